cbfp_blk_exp: RTL and testbench

Block-exponent detector for the CBFP stage of the FFT pipeline. It sits directly upstream of the CBFP block buffer and observes the same 16-lane sample stream that the buffer stores. Over each 64-sample block it finds the minimum count of redundant sign bits, which is the shift the normalizer may apply without overflow. It then emits that exponent, one pulse per block, timed to arrive before the buffer starts replaying the block.

---
 rtl/cbfp_pkg.sv | 17 +
 rtl/cbfp_rsb_cnt.sv | 34 +++
 rtl/cbfp_blk_exp.sv | 128 ++++++++++++
 tb/tb_cbfp_blk_exp.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/cbfp_pkg.sv
// ============================================================================
// cbfp_pkg: shared defaults and types for the CBFP buffer, exponent detector
// and normalizer.  Revision: 1.0
// ============================================================================
`default_nettype none

package cbfp_pkg;
  localparam int CBFP_ARRAY_SIZE = 16;
  localparam int CBFP_DIN_SIZE   = 23;
  localparam int CBFP_BUF_DEPTH  = 64;
  localparam int CBFP_DOUT_SIZE  = 11;
  localparam int CBFP_EXP_W      = $clog2(CBFP_DIN_SIZE);

  typedef logic [CBFP_EXP_W-1:0] cbfp_exp_t;
endpackage

`default_nettype wire

// File: rtl/cbfp_rsb_cnt.sv
// ============================================================================
// cbfp_rsb_cnt: combinational count of redundant sign bits of one sample.
// Revision: 1.0
// ============================================================================
`default_nettype none

module cbfp_rsb_cnt
  import cbfp_pkg::*;
#(
  parameter int din_size = CBFP_DIN_SIZE,
  localparam int exp_w   = $clog2(din_size)
) (
  input  logic signed [din_size-1:0] i_sample,
  output logic        [exp_w-1:0]    o_rsb
);

  logic w_run;

  // Scan down from just below the sign bit until the first differing bit.
  always_comb begin
    o_rsb = '0;
    w_run = 1'b1;
    for (int i = din_size - 2; i >= 0; i--) begin
      if (w_run && (i_sample[i] == i_sample[din_size-1])) begin
        o_rsb = o_rsb + exp_w'(1);
      end else begin
        w_run = 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/cbfp_blk_exp.sv
// ============================================================================
// cbfp_blk_exp: per-block minimum redundant-sign-bit detector (block exponent).
// Optional clamp to din_size-dout_size when CBFP_EXP_SAT_EN is defined.
// Revision: 1.0
// ============================================================================
`default_nettype none

module cbfp_blk_exp
  import cbfp_pkg::*;
#(
  parameter int array_size   = CBFP_ARRAY_SIZE,
  parameter int din_size     = CBFP_DIN_SIZE,
  parameter int buffer_depth = CBFP_BUF_DEPTH,
  parameter int dout_size    = CBFP_DOUT_SIZE,
  localparam int beats       = buffer_depth / array_size,
  localparam int exp_w       = $clog2(din_size)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       valid_in,
  input  logic                       blk_start,
  input  logic signed [din_size-1:0] din [0:array_size-1],
  output logic        [exp_w-1:0]    blk_exp,
  output logic                       valid_out,
  output logic                       err_out
);

  localparam int               c_cnt_w = (beats > 1) ? $clog2(beats) : 1;
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(beats - 1);
  localparam logic [exp_w-1:0] c_max   = exp_w'(din_size - 1);
  localparam logic [exp_w-1:0] c_sat   = exp_w'(din_size - dout_size);
`ifdef CBFP_EXP_SAT_EN
  localparam bit               c_sat_en = 1'b1;
`else
  localparam bit               c_sat_en = 1'b0;
`endif

  logic [exp_w-1:0]   w_rsb    [0:array_size-1];
  logic [exp_w-1:0]   r_s1_rsb [0:array_size-1];
  logic [c_cnt_w-1:0] r_cnt;
  logic [c_cnt_w-1:0] w_cnt_nxt;
  logic               w_first;
  logic               w_last;
  logic               w_trunc;
  logic               r_s1_vld;
  logic               r_s1_first;
  logic               r_s1_last;
  logic               r_s1_err;
  logic [exp_w-1:0]   r_acc;
  logic [exp_w-1:0]   w_lane_min;
  logic [exp_w-1:0]   w_blk_min;
  logic [exp_w-1:0]   w_exp_out;

  generate
    for (genvar l = 0; l < array_size; l++) begin : g_lane
      cbfp_rsb_cnt #(
        .din_size (din_size)
      ) u_rsb (
        .i_sample (din[l]),
        .o_rsb    (w_rsb[l])
      );
    end
  endgenerate

  // blk_start forces beat 0 regardless of where the counter was.
  always_comb begin
    w_first   = blk_start || (r_cnt == '0);
    w_last    = blk_start ? (beats == 1) : (r_cnt == c_last);
    w_trunc   = blk_start && (r_cnt != '0);
    w_cnt_nxt = w_last ? '0 : (w_first ? c_cnt_w'(1) : r_cnt + c_cnt_w'(1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt      <= '0;
      r_s1_vld   <= 1'b0;
      r_s1_first <= 1'b0;
      r_s1_last  <= 1'b0;
      r_s1_err   <= 1'b0;
    end else begin
      r_s1_vld <= valid_in;
      if (valid_in) begin
        r_cnt      <= w_cnt_nxt;
        r_s1_first <= w_first;
        r_s1_last  <= w_last;
        r_s1_err   <= w_trunc;
        for (int l = 0; l < array_size; l++) begin
          r_s1_rsb[l] <= w_rsb[l];
        end
      end
    end
  end

  // A first beat reloads from the lane minimum, so a truncated block never leaks in.
  always_comb begin
    w_lane_min = r_s1_rsb[0];
    for (int l = 1; l < array_size; l++) begin
      if (r_s1_rsb[l] < w_lane_min) begin
        w_lane_min = r_s1_rsb[l];
      end
    end
    w_blk_min = (r_s1_first || (w_lane_min < r_acc)) ? w_lane_min : r_acc;
    w_exp_out = (c_sat_en && (w_blk_min > c_sat)) ? c_sat : w_blk_min;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc     <= c_max;
      blk_exp   <= '0;
      valid_out <= 1'b0;
      err_out   <= 1'b0;
    end else begin
      valid_out <= 1'b0;
      err_out   <= 1'b0;
      if (r_s1_vld) begin
        r_acc   <= w_blk_min;
        err_out <= r_s1_err;
        if (r_s1_last) begin
          blk_exp   <= w_exp_out;
          valid_out <= 1'b1;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_cbfp_blk_exp.sv
// ============================================================================
// tb_cbfp_blk_exp: directed self-checking bench for cbfp_blk_exp.
// Revision: 1.0
// ============================================================================
`default_nettype none

`ifdef CBFP_EXP_SAT_EN
`define XP(v) (((v) > 12) ? 12 : (v))
`else
`define XP(v) (v)
`endif

module tb_cbfp_blk_exp;

  logic               clk = 1'b0;
  logic               rst;
  logic               valid_in;
  logic               blk_start;
  logic signed [22:0] din [0:15];
  logic        [4:0]  blk_exp;
  logic               valid_out;
  logic               err_out;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int n_pulse = 0;
  int n_err   = 0;
  int last_cyc;
  int err_cyc;
  int start_cyc;
  int p_exp [0:15];
  int p_cyc [0:15];

  always #5 clk = ~clk;

  cbfp_blk_exp u_dut (
    .clk       (clk),
    .rst       (rst),
    .valid_in  (valid_in),
    .blk_start (blk_start),
    .din       (din),
    .blk_exp   (blk_exp),
    .valid_out (valid_out),
    .err_out   (err_out)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (valid_out) begin
      if (n_pulse < 16) begin
        p_exp[n_pulse] = int'(blk_exp);
        p_cyc[n_pulse] = cyc;
      end
      n_pulse++;
    end
    if (err_out) begin
      n_err++;
      err_cyc = cyc;
    end
  end

  task automatic fill(input logic signed [22:0] v);
    for (int l = 0; l < 16; l++) din[l] = v;
  endtask

  task automatic send(input logic s);
    @(negedge clk);
    valid_in  = 1'b1;
    blk_start = s;
    @(posedge clk);
    #1;
    last_cyc = cyc;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      valid_in  = 1'b0;
      blk_start = 1'b0;
    end
    #1;
  endtask

  task automatic clr();
    n_pulse = 0;
    n_err   = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1; valid_in = 1'b0; blk_start = 1'b0; fill(23'sd0);
    repeat (3) @(negedge clk);
    #1;
    n_tests++; if (blk_exp !== 5'd0) begin n_fail++; $display("FAIL reset_exp: got %0d expected 0", blk_exp); end
    n_tests++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", valid_out); end
    n_tests++; if (err_out !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", err_out); end
    rst = 1'b0;
    idle(2);
    clr();
  endtask

  task automatic test_ones();
    clr();
    fill(23'sd1);
    send(1'b1); send(1'b0); send(1'b0); send(1'b0);
    idle(4);
    n_tests++; if (n_pulse !== 1) begin n_fail++; $display("FAIL ones_pulses: got %0d expected 1", n_pulse); end
    n_tests++; if (p_exp[0] !== `XP(21)) begin n_fail++; $display("FAIL ones_exp: got %0d expected %0d", p_exp[0], `XP(21)); end
    n_tests++; if (p_cyc[0] !== last_cyc + 1) begin n_fail++; $display("FAIL ones_latency: got cycle %0d expected %0d", p_cyc[0], last_cyc + 1); end
    n_tests++; if (n_err !== 0) begin n_fail++; $display("FAIL ones_err: got %0d expected 0", n_err); end
  endtask

  task automatic test_single_lane();
    clr();
    fill(23'sd0);
    send(1'b1); send(1'b0);
    din[5] = 23'sh100000;
    send(1'b0);
    fill(23'sd0);
    send(1'b0);
    idle(4);
    n_tests++; if (n_pulse !== 1) begin n_fail++; $display("FAIL lane5_pulses: got %0d expected 1", n_pulse); end
    n_tests++; if (p_exp[0] !== 1) begin n_fail++; $display("FAIL lane5_exp: got %0d expected 1", p_exp[0]); end
    clr();
    send(1'b1); send(1'b0); send(1'b0);
    din[0] = 23'sh400000;
    send(1'b0);
    fill(23'sd0);
    idle(4);
    n_tests++; if (n_pulse !== 1) begin n_fail++; $display("FAIL lane0neg_pulses: got %0d expected 1", n_pulse); end
    n_tests++; if (p_exp[0] !== 0) begin n_fail++; $display("FAIL lane0neg_exp: got %0d expected 0", p_exp[0]); end
  endtask

  task automatic test_back_to_back();
    clr();
    fill(23'sh400);   send(1'b1); send(1'b0); send(1'b0); send(1'b0);
    fill(23'sh40000); send(1'b1); send(1'b0); send(1'b0); send(1'b0);
    fill(23'sh400);   send(1'b1); send(1'b0); send(1'b0); send(1'b0);
    idle(4);
    n_tests++; if (n_pulse !== 3) begin n_fail++; $display("FAIL b2b_pulses: got %0d expected 3", n_pulse); end
    n_tests++; if (p_exp[0] !== 11) begin n_fail++; $display("FAIL b2b_exp0: got %0d expected 11", p_exp[0]); end
    n_tests++; if (p_exp[1] !== 3) begin n_fail++; $display("FAIL b2b_exp1: got %0d expected 3", p_exp[1]); end
    n_tests++; if (p_exp[2] !== 11) begin n_fail++; $display("FAIL b2b_exp2: got %0d expected 11", p_exp[2]); end
    n_tests++; if (p_cyc[1] - p_cyc[0] !== 4) begin n_fail++; $display("FAIL b2b_spacing01: got %0d expected 4", p_cyc[1] - p_cyc[0]); end
    n_tests++; if (p_cyc[2] - p_cyc[1] !== 4) begin n_fail++; $display("FAIL b2b_spacing12: got %0d expected 4", p_cyc[2] - p_cyc[1]); end
    n_tests++; if (n_err !== 0) begin n_fail++; $display("FAIL b2b_err: got %0d expected 0", n_err); end
  endtask

  task automatic run_mix(input int maxgap);
    logic signed [22:0] vals [0:3];
    vals[0] = 23'sh8000; vals[1] = 23'sh20; vals[2] = 23'sh1000; vals[3] = 23'sh100;
    for (int b = 0; b < 4; b++) begin
      fill(vals[b]);
      send(b == 0);
      if (b < 3) idle(int'($urandom_range(0, maxgap)));
    end
    idle(4);
  endtask

  task automatic test_gaps();
    clr();
    run_mix(0);
    n_tests++; if (n_pulse !== 1) begin n_fail++; $display("FAIL nogap_pulses: got %0d expected 1", n_pulse); end
    n_tests++; if (p_exp[0] !== 6) begin n_fail++; $display("FAIL nogap_exp: got %0d expected 6", p_exp[0]); end
    for (int r = 0; r < 3; r++) begin
      clr();
      run_mix(5);
      n_tests++; if (n_pulse !== 1) begin n_fail++; $display("FAIL gap_pulses[%0d]: got %0d expected 1", r, n_pulse); end
      n_tests++; if (p_exp[0] !== 6) begin n_fail++; $display("FAIL gap_exp[%0d]: got %0d expected 6", r, p_exp[0]); end
    end
  endtask

  task automatic test_truncate();
    clr();
    fill(23'sh100000);
    send(1'b1); send(1'b0);
    fill(23'sh10000);
    send(1'b1);
    start_cyc = last_cyc;
    send(1'b0); send(1'b0); send(1'b0);
    idle(4);
    n_tests++; if (n_err !== 1) begin n_fail++; $display("FAIL trunc_err_count: got %0d expected 1", n_err); end
    n_tests++; if (err_cyc !== start_cyc + 1) begin n_fail++; $display("FAIL trunc_err_timing: got cycle %0d expected %0d", err_cyc, start_cyc + 1); end
    n_tests++; if (n_pulse !== 1) begin n_fail++; $display("FAIL trunc_pulses: got %0d expected 1", n_pulse); end
    n_tests++; if (p_exp[0] !== 5) begin n_fail++; $display("FAIL trunc_exp: got %0d expected 5", p_exp[0]); end
    n_tests++; if (p_cyc[0] !== last_cyc + 1) begin n_fail++; $display("FAIL trunc_latency: got cycle %0d expected %0d", p_cyc[0], last_cyc + 1); end
  endtask

  task automatic test_rst_mid();
    clr();
    fill(23'sh100000);
    send(1'b1); send(1'b0); send(1'b0);
    @(negedge clk);
    valid_in = 1'b0; blk_start = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_tests++; if (blk_exp !== 5'd0) begin n_fail++; $display("FAIL rstmid_exp: got %0d expected 0", blk_exp); end
    n_tests++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid: got %b expected 0", valid_out); end
    n_tests++; if (err_out !== 1'b0) begin n_fail++; $display("FAIL rstmid_err: got %b expected 0", err_out); end
    fill(23'sh4000);
    send(1'b0); send(1'b0); send(1'b0); send(1'b0);
    idle(4);
    n_tests++; if (n_pulse !== 1) begin n_fail++; $display("FAIL rstmid_pulses: got %0d expected 1", n_pulse); end
    n_tests++; if (p_exp[0] !== 7) begin n_fail++; $display("FAIL rstmid_new_exp: got %0d expected 7", p_exp[0]); end
  endtask

  initial begin
    test_reset();
    test_ones();
    test_single_lane();
    test_back_to_back();
    test_gaps();
    test_truncate();
    test_rst_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`undef XP

`default_nettype wire
